sendharq_pingpong_sched: RTL and testbench
==========================================

// Module: sendharq_pingpong_sched
// PURPOSE
//  Schedules the ping/pong combine buffers feeding the HARQ send FSM. Tells the upstream
//  combine writer which buffer it may fill, latches each fill's amount and user index, and
//  issues one Ping or Pong send request at a time, strictly oldest-first.
//  Frees a buffer when the send FSM signals completion, and flags protocol errors.
// PARAMETERS
//  REQ_TIMEOUT  1023  cycles a request may wait for Busy before o_timeout_err sets (10-bit counter)
// PORTS
//  i_core_clk                       in   1   core clock
//  i_rx_rstn                        in   1   asynchronous active-low reset
//  i_rdm_slot_start                 in   1   synchronous slot flush; coincides with send-FSM fsm reset
//  i_fill_done                      in   1   1-cycle pulse: writer finished buffer o_wr_buf_sel
//  i_fill_amount                    in   16  sample amount for the finished buffer ([15:4] beats, [3:0] tail)
//  i_fill_user_index                in   4   user index for the finished buffer
//  o_wr_buf_avail                   out  1   buffer o_wr_buf_sel is EMPTY and may be written
//  o_wr_buf_sel                     out  1   0 = ping, 1 = pong; next buffer the writer fills
//  o_SENDHARQ_Data_Ping_request     out  1   send request, ping buffer
//  o_SENDHARQ_Data_Pong_request     out  1   send request, pong buffer
//  o_SENDHARQ_Data_Ping_Add_Amount  out  16  latched ping amount, stable while ping not EMPTY
//  o_SENDHARQ_Data_Pong_Add_Amount  out  16  latched pong amount, stable while pong not EMPTY
//  o_SENDHARQ_Data_Ping_User_Index  out  4   latched ping user index
//  o_SENDHARQ_Data_Pong_User_Index  out  4   latched pong user index
//  i_SENDHARQ_Data_Ping_Busy        in   1   send FSM draining ping
//  i_SENDHARQ_Data_Pong_Busy        in   1   send FSM draining pong
//  i_SENDHARQ_Data_Ping_Comp        in   1   ping drain complete (high 1-2 cycles)
//  i_SENDHARQ_Data_Pong_Comp        in   1   pong drain complete
//  o_sent_count                     out  8   buffers completed this slot; saturates at 255
//  o_overflow_err                   out  1   sticky: i_fill_done while o_wr_buf_avail = 0
//  o_timeout_err                    out  1   sticky: request waited > REQ_TIMEOUT cycles for Busy
// BEHAVIOUR
//  Reset / slot flush: all outputs 0; both buffers EMPTY; wr_sel = rd_sel = 0 (ping); FSM to S_IDLE.
//    Slot flush drops requests and state regardless of Busy; counters and errors clear.
//  Buffer state per buffer: EMPTY -> FULL (i_fill_done targeting it) -> EMPTY (rising edge of its Comp).
//  i_fill_done with o_wr_buf_avail = 1:
//    - amount and index latch into the selected buffer; buffer -> FULL; wr_sel toggles.
//    - If i_fill_amount == 0: nothing latches, buffer stays EMPTY, wr_sel does not toggle.
//  i_fill_done with o_wr_buf_avail = 0: ignored; o_overflow_err <= 1.
//  o_wr_buf_avail = (state of buffer wr_sel == EMPTY), registered.
//  Scheduler FSM:
//    S_IDLE -> S_REQ when buffer rd_sel is FULL; the request for rd_sel is set at that edge.
//    S_REQ  -> S_BUSY when that buffer's Busy = 1; the request drops at that edge, so the request
//              is never high when the send FSM returns to IDLE. The wait counter counts S_REQ cycles.
//              Count > REQ_TIMEOUT sets o_timeout_err; the FSM stays in S_REQ.
//    S_BUSY -> S_DONE on a rising edge of that buffer's Comp: buffer -> EMPTY, rd_sel toggles,
//              o_sent_count++.
//    S_DONE -> S_IDLE after one cycle. The gap guarantees the send FSM has passed its ADJ state.
//  Ping and pong requests are never high together. Order follows fill order; there is no priority.
//  Latency: i_fill_done in cycle N (FSM in S_IDLE, rd_sel matches) -> request high from cycle N+2.
//  Simultaneous i_fill_done and Comp: both apply. The freed buffer's o_wr_buf_avail rises the next cycle.
//  Comp or Busy for the non-selected buffer is ignored. A Comp edge seen in S_REQ is ignored.
//  Latched amount and index are not overwritten while the buffer is FULL (an overflow is ignored).
// TESTING
//  T1 single: fill ping (amt 16'h0035, usr 3) -> ping_request high at N+2, drops when Busy is seen;
//     Comp -> ping EMPTY, sent_count = 1, wr_sel = 1.
//  T2 back-to-back: fill ping then pong -> pong_request only after ping Comp + S_DONE gap;
//     requests never overlap; sent_count = 2.
//  T3 overflow: fill ping, fill pong, third i_fill_done -> o_overflow_err = 1;
//     latched amounts unchanged; both drain normally.
//  T4 zero amount: i_fill_done with amount 0 -> no request, wr_sel stays 0, o_wr_buf_avail stays 1.
//  T5 timeout: REQ_TIMEOUT = 8, Busy held low -> o_timeout_err set after 9 S_REQ cycles;
//     late Busy + Comp complete normally.
//  T6 flush mid-drain: i_rdm_slot_start during S_BUSY -> next cycle all requests 0, both EMPTY,
//     counters/errors 0, wr_sel = 0; async i_rx_rstn mid-request gives the same state immediately.

Source files
------------

// File: rtl/sendharq_pingpong_sched.sv
// Ping/pong combine-buffer scheduler for the HARQ send FSM: tracks buffer fill state
// and issues one oldest-first send request at a time.
module sendharq_pingpong_sched #(
    parameter int unsigned REQ_TIMEOUT = 1023
) (
    input  logic        i_core_clk,
    input  logic        i_rx_rstn,
    input  logic        i_rdm_slot_start,
    input  logic        i_fill_done,
    input  logic [15:0] i_fill_amount,
    input  logic [3:0]  i_fill_user_index,
    output logic        o_wr_buf_avail,
    output logic        o_wr_buf_sel,
    output logic        o_SENDHARQ_Data_Ping_request,
    output logic        o_SENDHARQ_Data_Pong_request,
    output logic [15:0] o_SENDHARQ_Data_Ping_Add_Amount,
    output logic [15:0] o_SENDHARQ_Data_Pong_Add_Amount,
    output logic [3:0]  o_SENDHARQ_Data_Ping_User_Index,
    output logic [3:0]  o_SENDHARQ_Data_Pong_User_Index,
    input  logic        i_SENDHARQ_Data_Ping_Busy,
    input  logic        i_SENDHARQ_Data_Pong_Busy,
    input  logic        i_SENDHARQ_Data_Ping_Comp,
    input  logic        i_SENDHARQ_Data_Pong_Comp,
    output logic [7:0]  o_sent_count,
    output logic        o_overflow_err,
    output logic        o_timeout_err
);

    localparam logic [9:0] TimeoutLim = 10'(REQ_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StReq, StBusy, StDone} state_e;

    state_e           state_q;
    logic [1:0]       full_q, full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q;
    logic             wr_avail_q;
    logic [1:0][15:0] amt_q;
    logic [1:0][3:0]  usr_q;
    logic [1:0]       comp_prev_q;
    logic [1:0]       comp_now, comp_rise, busy_now;
    logic [9:0]       wait_cnt_q;
    logic [7:0]       sent_cnt_q;
    logic             ping_req_q, pong_req_q;
    logic             ovf_q, tmo_q;
    logic             fill_ok, free_buf;

    assign busy_now  = {i_SENDHARQ_Data_Pong_Busy, i_SENDHARQ_Data_Ping_Busy};
    assign comp_now  = {i_SENDHARQ_Data_Pong_Comp, i_SENDHARQ_Data_Ping_Comp};
    assign comp_rise = comp_now & ~comp_prev_q;

    // Zero-amount fills are accepted but leave the buffer empty.
    assign fill_ok  = i_fill_done & wr_avail_q & (i_fill_amount != 16'd0);
    assign free_buf = (state_q == StBusy) & comp_rise[rd_sel_q];

    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        if (fill_ok) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (free_buf) begin
            full_d[rd_sel_q] = 1'b0;
        end
        if (i_rdm_slot_start) begin
            full_d   = '0;
            wr_sel_d = 1'b0;
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q     <= StIdle;
            full_q      <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_avail_q  <= 1'b0;
            amt_q       <= '0;
            usr_q       <= '0;
            comp_prev_q <= '0;
            wait_cnt_q  <= '0;
            sent_cnt_q  <= '0;
            ping_req_q  <= 1'b0;
            pong_req_q  <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else if (i_rdm_slot_start) begin
            state_q     <= StIdle;
            full_q      <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_avail_q  <= 1'b0;
            amt_q       <= '0;
            usr_q       <= '0;
            comp_prev_q <= '0;
            wait_cnt_q  <= '0;
            sent_cnt_q  <= '0;
            ping_req_q  <= 1'b0;
            pong_req_q  <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_sel_q    <= wr_sel_d;
            wr_avail_q  <= ~full_d[wr_sel_d];
            comp_prev_q <= comp_now;
            if (fill_ok) begin
                amt_q[wr_sel_q] <= i_fill_amount;
                usr_q[wr_sel_q] <= i_fill_user_index;
            end
            if (i_fill_done && !wr_avail_q) begin
                ovf_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (full_q[rd_sel_q]) begin
                        state_q    <= StReq;
                        wait_cnt_q <= '0;
                        ping_req_q <= ~rd_sel_q;
                        pong_req_q <= rd_sel_q;
                    end
                end
                StReq: begin
                    // Dropping the request on Busy keeps it low once the send FSM idles.
                    if (busy_now[rd_sel_q]) begin
                        state_q    <= StBusy;
                        ping_req_q <= 1'b0;
                        pong_req_q <= 1'b0;
                    end else if (wait_cnt_q == TimeoutLim) begin
                        tmo_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 10'd1;
                    end
                end
                StBusy: begin
                    if (free_buf) begin
                        state_q  <= StDone;
                        rd_sel_q <= ~rd_sel_q;
                        if (sent_cnt_q != 8'hFF) begin
                            sent_cnt_q <= sent_cnt_q + 8'd1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_wr_buf_avail                  = wr_avail_q;
    assign o_wr_buf_sel                    = wr_sel_q;
    assign o_SENDHARQ_Data_Ping_request    = ping_req_q;
    assign o_SENDHARQ_Data_Pong_request    = pong_req_q;
    assign o_SENDHARQ_Data_Ping_Add_Amount = amt_q[0];
    assign o_SENDHARQ_Data_Pong_Add_Amount = amt_q[1];
    assign o_SENDHARQ_Data_Ping_User_Index = usr_q[0];
    assign o_SENDHARQ_Data_Pong_User_Index = usr_q[1];
    assign o_sent_count                    = sent_cnt_q;
    assign o_overflow_err                  = ovf_q;
    assign o_timeout_err                   = tmo_q;

endmodule

// File: tb/tb_sendharq_pingpong_sched.sv
// Bench for sendharq_pingpong_sched: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sendharq_pingpong_sched;

    localparam int TMO = 8;
    localparam int PhIdle = 0, PhReq = 1, PhBusy = 2, PhDone = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        slot_start = 1'b0;
    logic        fill_done = 1'b0;
    logic [15:0] fill_amount = '0;
    logic [3:0]  fill_usr = '0;
    logic        ping_busy = 1'b0, pong_busy = 1'b0;
    logic        ping_comp = 1'b0, pong_comp = 1'b0;
    logic        avail, wr_sel, ping_req, pong_req;
    logic [15:0] ping_amt, pong_amt;
    logic [3:0]  ping_usr, pong_usr;
    logic [7:0]  sent;
    logic        ovf, tmo;

    always #5 clk = ~clk;

    sendharq_pingpong_sched #(.REQ_TIMEOUT(TMO)) dut (
        .i_core_clk                      (clk),
        .i_rx_rstn                       (rstn),
        .i_rdm_slot_start                (slot_start),
        .i_fill_done                     (fill_done),
        .i_fill_amount                   (fill_amount),
        .i_fill_user_index               (fill_usr),
        .o_wr_buf_avail                  (avail),
        .o_wr_buf_sel                    (wr_sel),
        .o_SENDHARQ_Data_Ping_request    (ping_req),
        .o_SENDHARQ_Data_Pong_request    (pong_req),
        .o_SENDHARQ_Data_Ping_Add_Amount (ping_amt),
        .o_SENDHARQ_Data_Pong_Add_Amount (pong_amt),
        .o_SENDHARQ_Data_Ping_User_Index (ping_usr),
        .o_SENDHARQ_Data_Pong_User_Index (pong_usr),
        .i_SENDHARQ_Data_Ping_Busy       (ping_busy),
        .i_SENDHARQ_Data_Pong_Busy       (pong_busy),
        .i_SENDHARQ_Data_Ping_Comp       (ping_comp),
        .i_SENDHARQ_Data_Pong_Comp       (pong_comp),
        .o_sent_count                    (sent),
        .o_overflow_err                  (ovf),
        .o_timeout_err                   (tmo)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffers waiting to be sent are kept in fill order in a queue.
    logic [1:0]  m_full;
    int          m_q[$];
    logic [15:0] m_amt[2];
    logic [3:0]  m_usr[2];
    logic        m_wr, m_avail, m_ovf, m_tmo;
    logic [1:0]  m_comp_prev;
    int          m_sent, m_phase, m_wait;

    task automatic model_reset();
        m_full = '0;
        m_q.delete();
        m_amt[0] = '0; m_amt[1] = '0;
        m_usr[0] = '0; m_usr[1] = '0;
        m_wr = 1'b0; m_avail = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0;
        m_comp_prev = '0;
        m_sent = 0; m_phase = PhIdle; m_wait = 0;
    endtask

    task automatic model_step();
        logic [1:0] busy, comp;
        logic       take;
        int         head;
        busy = {pong_busy, ping_busy};
        comp = {pong_comp, ping_comp};
        take = fill_done && m_avail && (fill_amount != 0);
        if (fill_done && !m_avail) m_ovf = 1'b1;
        head = (m_q.size() > 0) ? m_q[0] : 0;
        case (m_phase)
            PhIdle: if (m_q.size() > 0) begin m_phase = PhReq; m_wait = 0; end
            PhReq: begin
                m_wait++;
                if (busy[head]) m_phase = PhBusy;
                else if (m_wait > TMO) m_tmo = 1'b1;
            end
            PhBusy: if (comp[head] && !m_comp_prev[head]) begin
                m_full[head] = 1'b0;
                void'(m_q.pop_front());
                if (m_sent < 255) m_sent++;
                m_phase = PhDone;
            end
            default: m_phase = PhIdle;
        endcase
        if (take) begin
            m_amt[m_wr]  = fill_amount;
            m_usr[m_wr]  = fill_usr;
            m_full[m_wr] = 1'b1;
            m_q.push_back(int'(m_wr));
            m_wr = ~m_wr;
        end
        m_comp_prev = comp;
        m_avail = ~m_full[m_wr];
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn || slot_start) model_reset();
        else model_step();
    end

    always @(negedge clk) begin : compare
        logic exp_ping, exp_pong;
        if (started) begin
            exp_ping = (m_phase == PhReq) && (m_q.size() > 0) && (m_q[0] == 0);
            exp_pong = (m_phase == PhReq) && (m_q.size() > 0) && (m_q[0] == 1);
            check("avail", avail, m_avail);
            check("wr_sel", wr_sel, m_wr);
            check("ping_req", ping_req, exp_ping);
            check("pong_req", pong_req, exp_pong);
            check("ping_amt", ping_amt, m_amt[0]);
            check("pong_amt", pong_amt, m_amt[1]);
            check("ping_usr", ping_usr, m_usr[0]);
            check("pong_usr", pong_usr, m_usr[1]);
            check("sent", sent, m_sent);
            check("ovf", ovf, m_ovf);
            check("tmo", tmo, m_tmo);
            check("req_overlap", ping_req & pong_req, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] a, input logic [3:0] u);
        fill_done = 1'b1; fill_amount = a; fill_usr = u;
        tick();
        fill_done = 1'b0; fill_amount = '0; fill_usr = '0;
    endtask

    task automatic flush();
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
        tick();
    endtask

    task automatic wait_req(input int b);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (((b == 0) ? ping_req : pong_req) === 1'b1) seen = 1;
            else tick();
        end
        check("req_seen", seen, 1);
    endtask

    task automatic drain(input int b);
        wait_req(b);
        if (b == 0) ping_busy = 1'b1; else pong_busy = 1'b1;
        tick();
        ping_busy = 1'b0; pong_busy = 1'b0;
        if (b == 0) ping_comp = 1'b1; else pong_comp = 1'b1;
        tick();
        tick();
        ping_comp = 1'b0; pong_comp = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        started = 1;
        repeat (3) tick();
        check("rst_avail", avail, 0);
        check("rst_req", {ping_req, pong_req}, 0);
        check("rst_sent", sent, 0);
        rstn = 1'b1;
        tick();
        check("rst_avail_rise", avail, 1);

        // T1: single ping fill, request at N+2, dropped on Busy, freed on Comp.
        fill(16'h0035, 4'd3);
        check("t1_wr_sel", wr_sel, 1);
        check("t1_amt", ping_amt, 16'h0035);
        check("t1_usr", ping_usr, 4'd3);
        check("t1_req_n1", ping_req, 0);
        tick();
        check("t1_req_n2", ping_req, 1);
        ping_busy = 1'b1;
        tick();
        check("t1_req_drop", ping_req, 0);
        tick();
        ping_busy = 1'b0; ping_comp = 1'b1;
        tick();
        check("t1_sent", sent, 1);
        check("t1_avail", avail, 1);
        tick();
        ping_comp = 1'b0;
        tick();

        // T2: back-to-back ping/pong, pong request only after the done gap.
        flush();
        fill(16'h0100, 4'd5);
        fill(16'h0042, 4'd7);
        check("t2_pong_amt", pong_amt, 16'h0042);
        wait_req(0);
        ping_busy = 1'b1;
        tick();
        ping_busy = 1'b0; ping_comp = 1'b1;
        tick();
        ping_comp = 1'b0;
        check("t2_gap_done", pong_req, 0);
        tick();
        check("t2_gap_idle", pong_req, 0);
        tick();
        check("t2_pong_req", pong_req, 1);
        drain(1);
        check("t2_sent", sent, 2);

        // T3: overflow on a third fill leaves latched values intact.
        flush();
        fill(16'h0123, 4'd1);
        fill(16'h0456, 4'd2);
        fill(16'h0789, 4'd4);
        check("t3_ovf", ovf, 1);
        check("t3_ping_amt", ping_amt, 16'h0123);
        check("t3_pong_amt", pong_amt, 16'h0456);
        check("t3_pong_usr", pong_usr, 4'd2);
        drain(0);
        drain(1);
        check("t3_sent", sent, 2);

        // T4: zero amount is a no-op.
        flush();
        fill(16'h0000, 4'd9);
        check("t4_wr_sel", wr_sel, 0);
        check("t4_avail", avail, 1);
        repeat (4) tick();
        check("t4_req", {ping_req, pong_req}, 0);
        check("t4_amt", ping_amt, 0);

        // T5: timeout after 9 request cycles without Busy.
        flush();
        fill(16'h0077, 4'd2);
        tick();
        check("t5_req", ping_req, 1);
        repeat (8) tick();
        check("t5_tmo_early", tmo, 0);
        tick();
        check("t5_tmo", tmo, 1);
        drain(0);
        check("t5_sent", sent, 1);
        check("t5_tmo_sticky", tmo, 1);

        // T6: slot flush mid-drain, then async reset mid-request.
        flush();
        fill(16'h0011, 4'd1);
        fill(16'h0022, 4'd2);
        fill(16'h0033, 4'd3);
        drain(0);
        wait_req(1);
        pong_busy = 1'b1;
        tick();
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0; pong_busy = 1'b0;
        check("t6_req", {ping_req, pong_req}, 0);
        check("t6_sent", sent, 0);
        check("t6_errs", {ovf, tmo}, 0);
        check("t6_amt", {ping_amt, pong_amt}, 0);
        check("t6_wr_sel", wr_sel, 0);
        tick();
        check("t6_avail", avail, 1);
        fill(16'h0044, 4'd6);
        wait_req(0);
        #2 rstn = 1'b0;
        #1;
        check("t6_arst_req", ping_req, 0);
        check("t6_arst_amt", ping_amt, 0);
        check("t6_arst_avail", avail, 0);
        tick();
        rstn = 1'b1;
        tick();
        check("t6_arst_release", avail, 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
